// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares the UART transmit byte-pop interface between NCH byte-stream
// requesters (status reporter, register dump, debug echo, ...). Each
// uart_pop_i request is answered with exactly one byte and a one-cycle
// uart_ack_o strobe. Packets are atomic: once a channel is granted, it keeps
// the grant until it presents a byte with req_last_i, or until MAX_PKT bytes
// have been sent, whichever comes first. Channels are served round-robin.
//
// Optional feature macro: UART_ARB_TAG_EN
//   When defined, every grant starts with one tag byte TAG_BASE|ch. The tag
//   is not counted toward MAX_PKT. When undefined there is no TAG state.
//
// Parameters:
//   NCH       number of requesters (2..8)
//   MAX_PKT   bytes per grant before forced release, 0 = unlimited
//   TAG_BASE  tag byte base (low bits must be free for the channel index)
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   uart_pop_i   uart asks for the next TX byte (1-cycle pulse)
//   uart_data_o  byte to uart, valid only while uart_ack_o=1, else 8'h00
//   uart_ack_o   1-cycle strobe, uart_data_o is valid
//   req_valid_i  per-channel: a byte is available
//   req_data_i   per-channel byte, channel ch at [8*ch+7:8*ch]
//   req_last_i   per-channel: presented byte ends its packet
//   req_pop_o    per-channel 1-cycle strobe: byte consumed
//   grant_o      one-hot current owner, 0 when unlocked
//   busy_o       a packet is in progress
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int         NCH      = 4,
  parameter int         MAX_PKT  = 16,
  parameter logic [7:0] TAG_BASE = 8'hF0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_pop_i,
  output logic [7:0]       uart_data_o,
  output logic             uart_ack_o,
  input  logic [NCH-1:0]   req_valid_i,
  input  logic [NCH*8-1:0] req_data_i,
  input  logic [NCH-1:0]   req_last_i,
  output logic [NCH-1:0]   req_pop_o,
  output logic [NCH-1:0]   grant_o,
  output logic             busy_o
);

  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  // The counter only has to hold 0..MAX_PKT-1: the byte that would make it
  // reach MAX_PKT releases the grant and clears it instead.
  localparam int CNTW = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;

  if (NCH < 2 || NCH > 8) begin : g_bad_nch
    $error("uart_tx_arbiter: NCH must be in 2..8");
  end
  if ((TAG_BASE & 8'(NCH - 1)) != 8'h00) begin : g_bad_tag
    $error("uart_tx_arbiter: TAG_BASE low bits overlap the channel index");
  end

`ifdef UART_ARB_TAG_EN
  typedef enum logic [1:0] {S_IDLE, S_TAG, S_DATA} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DATA} state_t;
`endif

  state_t            state, state_n;
  logic              pend, pend_n;
  logic [CHW-1:0]    rr_ptr, rr_n;
  logic [CHW-1:0]    gnt_ch, gnt_n;
  logic [CNTW-1:0]   byte_cnt, cnt_n;

  logic              scan_found;
  logic [CHW-1:0]    scan_ch;
  logic [CHW-1:0]    cand;
  logic [7:0]        req_bytes [NCH];
  logic              at_limit;
  logic              ack;
  logic [7:0]        data;
  logic [NCH-1:0]    pops;

  // State register. Reset parks the round-robin pointer on the last channel
  // so channel 0 is the first one scanned.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pend     <= 1'b0;
      rr_ptr   <= CHW'(NCH - 1);
      gnt_ch   <= '0;
      byte_cnt <= '0;
    end else begin
      state    <= state_n;
      pend     <= pend_n;
      rr_ptr   <= rr_n;
      gnt_ch   <= gnt_n;
      byte_cnt <= cnt_n;
    end
  end

  // Round-robin scan starting just after the last served channel, so the
  // channel that was just served has lowest priority.
  always_comb begin
    scan_found = 1'b0;
    scan_ch    = '0;
    cand       = '0;
    for (int i = 1; i <= NCH; i++) begin
      cand = CHW'((int'(rr_ptr) + i) % NCH);
      if (!scan_found && req_valid_i[cand]) begin
        scan_found = 1'b1;
        scan_ch    = cand;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      req_bytes[c] = req_data_i[8*c +: 8];
    end
  end

  assign at_limit = (MAX_PKT != 0) && (int'(byte_cnt) == MAX_PKT - 1);

  // Next-state and response logic. Selection in IDLE never acks in the same
  // cycle; the uart_pop_i of the current cycle already counts as a request
  // for selection so the first byte still arrives one cycle after the pop.
  always_comb begin
    state_n = state;
    pend_n  = pend | uart_pop_i;
    rr_n    = rr_ptr;
    gnt_n   = gnt_ch;
    cnt_n   = byte_cnt;
    ack     = 1'b0;
    data    = 8'h00;
    pops    = '0;
    case (state)
      S_IDLE: begin
        if ((pend || uart_pop_i) && scan_found) begin
          gnt_n = scan_ch;
          rr_n  = scan_ch;
          cnt_n = '0;
`ifdef UART_ARB_TAG_EN
          state_n = S_TAG;
`else
          state_n = S_DATA;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      S_TAG: begin
        if (pend) begin
          ack     = 1'b1;
          data    = TAG_BASE | 8'(gnt_ch);
          pend_n  = 1'b0;
          state_n = S_DATA;
        end
      end
`endif
      S_DATA: begin
        // A stalled owner simply keeps pend set; other channels are not
        // considered until the packet ends or the byte limit is hit.
        if (pend && req_valid_i[gnt_ch]) begin
          ack          = 1'b1;
          data         = req_bytes[gnt_ch];
          pops[gnt_ch] = 1'b1;
          pend_n       = 1'b0;
          if (req_last_i[gnt_ch] || at_limit) begin
            state_n = S_IDLE;
            cnt_n   = '0;
          end else if (MAX_PKT != 0) begin
            cnt_n = byte_cnt + CNTW'(1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are forced low during reset so an interrupted packet loses no
  // byte through a stray pop on the reset cycle.
  assign uart_ack_o  = ack & ~rst;
  assign uart_data_o = rst ? 8'h00 : data;
  assign req_pop_o   = rst ? '0 : pops;
  assign grant_o     = (rst || state == S_IDLE) ? '0 : (NCH'(1) << gnt_ch);
  assign busy_o      = |grant_o;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed self-checking bench for uart_tx_arbiter. A small requester model
// (per-channel byte list, last flags and enable) drives the request side and
// advances on req_pop_o; uart pops are issued one at a time and the returned
// bytes are compared with hand-computed sequences.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int NCH     = 4;
  localparam int MAX_PKT = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             uart_pop_i;
  logic [7:0]       uart_data_o;
  logic             uart_ack_o;
  logic [NCH-1:0]   req_valid_i;
  logic [NCH*8-1:0] req_data_i;
  logic [NCH-1:0]   req_last_i;
  logic [NCH-1:0]   req_pop_o;
  logic [NCH-1:0]   grant_o;
  logic             busy_o;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NCH     (NCH),
    .MAX_PKT (MAX_PKT),
    .TAG_BASE(8'hF0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_pop_i (uart_pop_i),
    .uart_data_o(uart_data_o),
    .uart_ack_o (uart_ack_o),
    .req_valid_i(req_valid_i),
    .req_data_i (req_data_i),
    .req_last_i (req_last_i),
    .req_pop_o  (req_pop_o),
    .grant_o    (grant_o),
    .busy_o     (busy_o)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [NCH][32];
  bit         lst [NCH][32];
  int         len [NCH];
  int         ptr [NCH];
  bit         en  [NCH];

  logic           seen_ack;
  logic [7:0]     seen_data;
  logic [NCH-1:0] seen_pop;
  logic [NCH-1:0] seen_grant;
  logic           seen_busy;
  int             ack_count;

  logic [7:0]     got_b;
  int             got_lat;
  logic [NCH-1:0] got_pop;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic driveInputs();
    for (int c = 0; c < NCH; c++) begin
      req_valid_i[c]      = en[c] && (ptr[c] < len[c]);
      req_data_i[8*c +: 8] = (ptr[c] < len[c]) ? mem[c][ptr[c]] : 8'h00;
      req_last_i[c]       = (ptr[c] < len[c]) ? lst[c][ptr[c]] : 1'b0;
    end
  endtask

  // One clock: drive inputs just after posedge, sample at negedge, advance
  // the requester model on the pops seen.
  task automatic applyStimulus(input logic pop);
    uart_pop_i = pop;
    driveInputs();
    @(negedge clk);
    seen_ack   = uart_ack_o;
    seen_data  = uart_data_o;
    seen_pop   = req_pop_o;
    seen_grant = grant_o;
    seen_busy  = busy_o;
    if (uart_ack_o) ack_count++;
    for (int c = 0; c < NCH; c++) begin
      if (req_pop_o[c]) ptr[c]++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic setByte(input int c, input int k, input logic [7:0] v, input bit last);
    mem[c][k] = v;
    lst[c][k] = last;
    if (k + 1 > len[c]) len[c] = k + 1;
  endtask

  task automatic resetDut();
    for (int c = 0; c < NCH; c++) begin
      len[c] = 0;
      ptr[c] = 0;
      en[c]  = 1'b0;
      for (int k = 0; k < 32; k++) lst[c][k] = 1'b0;
    end
    rst = 1'b1;
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    rst = 1'b0;
    ack_count = 0;
  endtask

  // Issue one uart pop and wait (bounded) for its ack; lat=0 means timeout.
  task automatic popByte(output logic [7:0] b, output int lat, output logic [NCH-1:0] popv);
    b    = 8'h00;
    lat  = 0;
    popv = '0;
    applyStimulus(1'b1);
    for (int k = 1; k <= 80; k++) begin
      applyStimulus(1'b0);
      if (seen_ack) begin
        lat  = k;
        b    = seen_data;
        popv = seen_pop;
        break;
      end
    end
  endtask

  initial begin
    logic [7:0] exp5 [22];
    int acks_before;

    rst        = 1'b1;
    uart_pop_i = 1'b0;
    ack_count  = 0;
    for (int c = 0; c < NCH; c++) begin
      len[c] = 0; ptr[c] = 0; en[c] = 1'b0;
    end
    driveInputs();

    // Test 1: single 3-byte packet on ch1, one-cycle pop->ack latency.
    resetDut();
    applyStimulus(1'b0);
    checkOutput("rst_ack", 32'(seen_ack), 32'd0);
    checkOutput("rst_grant", 32'(seen_grant), 32'd0);
    checkOutput("rst_busy", 32'(seen_busy), 32'd0);
    setByte(1, 0, 8'h12, 1'b0);
    setByte(1, 1, 8'h34, 1'b0);
    setByte(1, 2, 8'h56, 1'b1);
    en[1] = 1'b1;
    popByte(got_b, got_lat, got_pop);
    checkOutput("t1_b0", 32'(got_b), 32'h12);
    checkOutput("t1_lat0", 32'(got_lat), 32'd1);
    checkOutput("t1_pop0", 32'(got_pop), 32'b0010);
    checkOutput("t1_grant", 32'(seen_grant), 32'b0010);
    popByte(got_b, got_lat, got_pop);
    checkOutput("t1_b1", 32'(got_b), 32'h34);
    checkOutput("t1_lat1", 32'(got_lat), 32'd1);
    popByte(got_b, got_lat, got_pop);
    checkOutput("t1_b2", 32'(got_b), 32'h56);
    checkOutput("t1_pop2", 32'(got_pop), 32'b0010);
    applyStimulus(1'b0);
    checkOutput("t1_grant_end", 32'(seen_grant), 32'd0);
    checkOutput("t1_busy_end", 32'(seen_busy), 32'd0);

    // Test 2: ch0 and ch2 contend; ch0 first, then ch2, then ch0 again.
    resetDut();
    setByte(0, 0, 8'hA1, 1'b0); setByte(0, 1, 8'hA2, 1'b1);
    setByte(0, 2, 8'hA3, 1'b0); setByte(0, 3, 8'hA4, 1'b1);
    setByte(2, 0, 8'hC1, 1'b0); setByte(2, 1, 8'hC2, 1'b1);
    en[0] = 1'b1; en[2] = 1'b1;
    popByte(got_b, got_lat, got_pop); checkOutput("t2_b0", 32'(got_b), 32'hA1);
    popByte(got_b, got_lat, got_pop); checkOutput("t2_b1", 32'(got_b), 32'hA2);
    popByte(got_b, got_lat, got_pop); checkOutput("t2_b2", 32'(got_b), 32'hC1);
    checkOutput("t2_grant_ch2", 32'(seen_grant), 32'b0100);
    popByte(got_b, got_lat, got_pop); checkOutput("t2_b3", 32'(got_b), 32'hC2);
    popByte(got_b, got_lat, got_pop); checkOutput("t2_b4", 32'(got_b), 32'hA3);
    popByte(got_b, got_lat, got_pop); checkOutput("t2_b5", 32'(got_b), 32'hA4);

    // Test 3: pop with nothing valid, then ch3 shows up.
    resetDut();
    applyStimulus(1'b1);
    for (int k = 0; k < 50; k++) applyStimulus(1'b0);
    checkOutput("t3_noack", 32'(ack_count), 32'd0);
    setByte(3, 0, 8'hAB, 1'b1);
    en[3] = 1'b1;
    applyStimulus(1'b0);
    checkOutput("t3_sel_noack", 32'(seen_ack), 32'd0);
    applyStimulus(1'b0);
    checkOutput("t3_ack", 32'(seen_ack), 32'd1);
    checkOutput("t3_data", 32'(seen_data), 32'hAB);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0);
    checkOutput("t3_one_ack", 32'(ack_count), 32'd1);

    // Test 4: owner ch1 stalls mid-packet while ch0 is valid.
    resetDut();
    setByte(1, 0, 8'h11, 1'b0); setByte(1, 1, 8'h22, 1'b0); setByte(1, 2, 8'h33, 1'b1);
    setByte(0, 0, 8'h01, 1'b1);
    en[1] = 1'b1;
    popByte(got_b, got_lat, got_pop);
    checkOutput("t4_b0", 32'(got_b), 32'h11);
    en[1] = 1'b0; en[0] = 1'b1;
    acks_before = ack_count;
    applyStimulus(1'b1);
    for (int k = 0; k < 20; k++) applyStimulus(1'b0);
    checkOutput("t4_stall_noack", 32'(ack_count - acks_before), 32'd0);
    checkOutput("t4_stall_grant", 32'(seen_grant), 32'b0010);
    checkOutput("t4_stall_busy", 32'(seen_busy), 32'd1);
    en[1] = 1'b1;
    applyStimulus(1'b0);
    checkOutput("t4_resume_ack", 32'(seen_ack), 32'd1);
    checkOutput("t4_resume_data", 32'(seen_data), 32'h22);
    checkOutput("t4_resume_pop", 32'(seen_pop), 32'b0010);
    popByte(got_b, got_lat, got_pop); checkOutput("t4_b2", 32'(got_b), 32'h33);
    popByte(got_b, got_lat, got_pop); checkOutput("t4_ch0", 32'(got_b), 32'h01);
    checkOutput("t4_ch0_pop", 32'(got_pop), 32'b0001);

    // Test 5: ch0 streams 20 bytes without last; forced release after 16.
    resetDut();
    for (int k = 0; k < 20; k++) setByte(0, k, 8'(8'h40 + k), 1'b0);
    setByte(1, 0, 8'hB0, 1'b0); setByte(1, 1, 8'hB1, 1'b1);
    en[0] = 1'b1; en[1] = 1'b1;
    for (int k = 0; k < 16; k++) exp5[k] = 8'(8'h40 + k);
    exp5[16] = 8'hB0; exp5[17] = 8'hB1;
    for (int k = 0; k < 4; k++) exp5[18 + k] = 8'(8'h50 + k);
    for (int k = 0; k < 22; k++) begin
      popByte(got_b, got_lat, got_pop);
      checkOutput($sformatf("t5_b%0d", k), 32'(got_b), 32'(exp5[k]));
    end

    // Test 6: reset mid-packet abandons it; priority restarts at ch0.
    resetDut();
    setByte(2, 0, 8'hCD, 1'b0); setByte(2, 1, 8'hEF, 1'b1);
    en[2] = 1'b1;
    popByte(got_b, got_lat, got_pop);
`ifdef UART_ARB_TAG_EN
    checkOutput("t6_tag", 32'(got_b), 32'hF2);
`else
    checkOutput("t6_b0", 32'(got_b), 32'hCD);
`endif
    rst = 1'b1;
    applyStimulus(1'b1);
    checkOutput("t6_rst_ack", 32'(seen_ack), 32'd0);
    checkOutput("t6_rst_pop", 32'(seen_pop), 32'd0);
    checkOutput("t6_rst_grant", 32'(seen_grant), 32'd0);
    checkOutput("t6_rst_data", 32'(seen_data), 32'd0);
    rst = 1'b0;
    setByte(0, 0, 8'h0A, 1'b1);
    en[0] = 1'b1;
    popByte(got_b, got_lat, got_pop);
`ifdef UART_ARB_TAG_EN
    checkOutput("t6_tag0", 32'(got_b), 32'hF0);
    popByte(got_b, got_lat, got_pop);
`endif
    checkOutput("t6_ch0", 32'(got_b), 32'h0A);
    checkOutput("t6_ch0_pop", 32'(got_pop), 32'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
